// File: rtl/downscale_avg2x2.sv
// downscale_avg2x2: 2x2 box-average downscaler, 640x480 RGB444 raster in,
// one 320x240 frame-buffer write per block out.
// Even lines hold horizontal pair sums in a line buffer. Odd lines add the
// buffered sums for the same column, round, and emit one write per block.
module downscale_avg2x2 #(
  parameter int unsigned IN_W   = 640,
  parameter int unsigned IN_H   = 480,
  parameter int unsigned OUT_W  = 320,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_25MHz,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic [11:0]       pixel_in,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [11:0]       out_pixel,
  output logic              frame_done
);

  localparam logic [9:0]        IN_W_L    = 10'(IN_W);
  localparam logic [9:0]        IN_H_L    = 10'(IN_H);
  localparam logic [ADDR_W-1:0] OUT_W_A   = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * IN_H / 2 - 1);

  logic              left_valid;
  logic              tag_valid;
  logic [11:0]       left_pix;
  logic [8:0]        line_tag;
  logic [14:0]       line_buf [OUT_W];

  logic              accept;
  logic              pair;
  logic              store;
  logic              emit;
  logic [8:0]        col;
  logic [8:0]        row;
  logic [14:0]       hsum;
  logic [14:0]       above;
  logic [5:0]        vsum;
  logic [11:0]       avg;
  logic [ADDR_W-1:0] addr;

  // Accept qualification, horizontal/vertical sums, rounding and block address.
  always_comb begin
    hsum   = '0;
    vsum   = '0;
    avg    = '0;
    accept = in_valid && (x_pixel < IN_W_L) && (y_pixel < IN_H_L);
    col    = x_pixel[9:1];
    row    = y_pixel[9:1];
    pair   = accept && x_pixel[0] && left_valid;
    store  = pair && !y_pixel[0];
    emit   = pair && y_pixel[0] && tag_valid && (line_tag == row);
    above  = line_buf[col];
    for (int unsigned c = 0; c < 3; c++) begin
      hsum[5*c +: 5] = {1'b0, left_pix[4*c +: 4]} + {1'b0, pixel_in[4*c +: 4]};
      // Max 60 + 2 fits 6 bits, so the rounded quotient never exceeds 15.
      vsum           = {1'b0, hsum[5*c +: 5]} + {1'b0, above[5*c +: 5]} + 6'd2;
      avg[4*c +: 4]  = vsum[5:2];
    end
    addr = ADDR_W'(row) * OUT_W_A + ADDR_W'(col);
  end

  // Pairing state, even-line tag and registered output strobe.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
      left_valid <= 1'b0;
      tag_valid  <= 1'b0;
      left_pix   <= '0;
      line_tag   <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && (addr == LAST_ADDR);
      if (emit) begin
        out_addr  <= addr;
        out_pixel <= avg;
      end
      if (accept && !x_pixel[0]) begin
        left_pix   <= pixel_in;
        left_valid <= 1'b1;
      end else begin
        left_valid <= 1'b0;
      end
      if (store) begin
        line_tag  <= row;
        tag_valid <= 1'b1;
      end
    end
  end

  // Line buffer of horizontal pair sums; contents survive reset.
  always_ff @(posedge clk_25MHz) begin
    if (store) line_buf[col] <= hsum;
  end

endmodule

// File: tb/tb_downscale_avg2x2.sv
module tb_downscale_avg2x2;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [11:0] pixel_in;
  logic        out_valid;
  logic [16:0] out_addr;
  logic [11:0] out_pixel;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  downscale_avg2x2 #(.IN_W(640), .IN_H(480), .OUT_W(320), .ADDR_W(17)) dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_pixel   (x_pixel),
    .y_pixel   (y_pixel),
    .pixel_in  (pixel_in),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_pixel (out_pixel),
    .frame_done(frame_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Reference model: raw pixels of the last even line, averaged on demand.
  logic [11:0] top_l [320];
  logic [11:0] top_r [320];
  logic [11:0] m_left;
  logic        m_left_valid;
  int          m_row;
  logic        m_row_valid;
  logic        exp_valid;
  logic [16:0] exp_addr;
  logic [11:0] exp_pix;
  logic        exp_done;

  function automatic logic [11:0] avg4(input logic [11:0] a, b, c, d);
    logic [11:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + int'(c[4*k +: 4]) + int'(d[4*k +: 4]);
      r[4*k +: 4] = 4'((s + 2) / 4);
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_left_valid = 1'b0;
    m_row_valid  = 1'b0;
    exp_valid    = 1'b0;
    exp_done     = 1'b0;
    exp_addr     = '0;
    exp_pix      = '0;
  endfunction

  function automatic void model(input logic v, input logic [9:0] x, input logic [9:0] y,
                                input logic [11:0] p);
    int c;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (!(v && x < 10'd640 && y < 10'd480)) begin
      m_left_valid = 1'b0;
    end else if (x[0] == 1'b0) begin
      m_left       = p;
      m_left_valid = 1'b1;
    end else if (m_left_valid) begin
      m_left_valid = 1'b0;
      c = int'(x) / 2;
      if (y[0] == 1'b0) begin
        top_l[c]    = m_left;
        top_r[c]    = p;
        m_row       = int'(y) / 2;
        m_row_valid = 1'b1;
      end else if (m_row_valid && m_row == int'(y) / 2) begin
        exp_valid = 1'b1;
        exp_addr  = 17'((int'(y) / 2) * 320 + c);
        exp_pix   = avg4(top_l[c], top_r[c], m_left, p);
        exp_done  = (exp_addr == 17'd76799);
      end
    end
  endfunction

  // Apply one input cycle, then sample just after the capturing edge.
  task automatic step(input logic v, input int x, input int y, input logic [11:0] p);
    in_valid = v;
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    pixel_in = p;
    @(posedge clk_25MHz);
    #1;
    model(v, 10'(x), 10'(y), p);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; x_pixel = '0; y_pixel = '0; pixel_in = '0;
    model_reset();
    repeat (2) @(posedge clk_25MHz);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_addr !== 17'd0 || out_pixel !== 12'h000 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got v=%b a=%0d p=%h d=%b want all zero", out_valid, out_addr, out_pixel, frame_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_block();
    logic [11:0] pix [4];
    pix[0] = 12'h000; pix[1] = 12'h111; pix[2] = 12'h222; pix[3] = 12'h333;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i % 2, i / 2, pix[i]);
      n_cmp++;
      if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL block i=%0d got v=%b a=%0d p=%h d=%b want v=%b a=%0d p=%h d=%b", i,
                 out_valid, out_addr, out_pixel, frame_done, exp_valid, exp_addr, exp_pix, exp_done);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_pixel !== 12'h222 || out_addr !== 17'd0) begin
      n_err++;
      $display("FAIL block_value got v=%b a=%0d p=%h want v=1 a=0 p=222", out_valid, out_addr, out_pixel);
    end
    step(1'b0, 0, 0, 12'h000);
    n_cmp++;
    if (out_valid !== 1'b0 || out_pixel !== 12'h222 || out_addr !== 17'd0) begin
      n_err++;
      $display("FAIL block_hold got v=%b a=%0d p=%h want v=0 a=0 p=222", out_valid, out_addr, out_pixel);
    end
  endtask

  task automatic test_rounding();
    logic [11:0] top [6];
    logic [11:0] bot [6];
    logic [11:0] want [3];
    top[0] = 12'hFFF; top[1] = 12'hFFF; top[2] = 12'hFFF; top[3] = 12'hFFF; top[4] = 12'h111; top[5] = 12'h111;
    bot[0] = 12'hFFF; bot[1] = 12'hFFF; bot[2] = 12'hFFF; bot[3] = 12'hEEE; bot[4] = 12'h111; bot[5] = 12'h222;
    want[0] = 12'hFFF; want[1] = 12'hFFF; want[2] = 12'h111;
    for (int x = 0; x < 6; x++) step(1'b1, x, 2, top[x]);
    for (int x = 0; x < 6; x++) begin
      step(1'b1, x, 3, bot[x]);
      n_cmp++;
      if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL rounding_model x=%0d got v=%b a=%0d p=%h want v=%b a=%0d p=%h", x,
                 out_valid, out_addr, out_pixel, exp_valid, exp_addr, exp_pix);
      end
      if (x % 2 == 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pixel !== want[x/2] || out_addr !== 17'(320 + x / 2)) begin
          n_err++;
          $display("FAIL rounding_value x=%0d got v=%b a=%0d p=%h want v=1 a=%0d p=%h", x,
                   out_valid, out_addr, out_pixel, 320 + x / 2, want[x/2]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int n50 = 0, n49 = 0, n51 = 0;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 640; x++) begin
        step(!(y == 1 && x == 100), x, y, 12'($urandom));
        n_cmp++;
        if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
          n_err++;
          $display("FAIL gap_stream y=%0d x=%0d got v=%b a=%0d p=%h want v=%b a=%0d p=%h", y, x,
                   out_valid, out_addr, out_pixel, exp_valid, exp_addr, exp_pix);
        end
        if (out_valid === 1'b1 && out_addr == 17'd50) n50++;
        if (out_valid === 1'b1 && out_addr == 17'd49) n49++;
        if (out_valid === 1'b1 && out_addr == 17'd51) n51++;
      end
    end
    n_cmp++;
    if (n50 != 0 || n49 != 1 || n51 != 1) begin
      n_err++;
      $display("FAIL gap_addrs got n49=%0d n50=%0d n51=%0d want 1 0 1", n49, n50, n51);
    end
  endtask

  task automatic test_random();
    for (int y = 6; y < 14; y++) begin
      for (int x = 0; x < 640; x++) begin
        step($urandom_range(0, 31) != 0, x, y, 12'($urandom));
        n_cmp++;
        if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
          n_err++;
          $display("FAIL random y=%0d x=%0d got v=%b a=%0d p=%h d=%b want v=%b a=%0d p=%h d=%b", y, x,
                   out_valid, out_addr, out_pixel, frame_done, exp_valid, exp_addr, exp_pix, exp_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_y3 = 0;
    for (int y = 2; y < 4; y++) begin
      for (int x = 0; x < 640 && !(y == 3 && x > 200); x++) begin
        step(1'b1, x, y, 12'($urandom));
        n_cmp++;
        if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix) begin
          n_err++;
          $display("FAIL pre_reset y=%0d x=%0d got v=%b a=%0d p=%h want v=%b a=%0d p=%h", y, x,
                   out_valid, out_addr, out_pixel, exp_valid, exp_addr, exp_pix);
        end
      end
    end
    reset = 1'b1; in_valid = 1'b0;
    #5;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_addr !== 17'd0 || out_pixel !== 12'h000 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got v=%b a=%0d p=%h d=%b want all zero", out_valid, out_addr, out_pixel, frame_done);
    end
    @(posedge clk_25MHz);
    #1;
    reset = 1'b0;
    for (int y = 3; y < 6; y++) begin
      for (int x = 0; x < 640 && !(y == 5 && x > 1); x++) begin
        step(1'b1, x, y, 12'($urandom));
        n_cmp++;
        if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
          n_err++;
          $display("FAIL post_reset y=%0d x=%0d got v=%b a=%0d p=%h want v=%b a=%0d p=%h", y, x,
                   out_valid, out_addr, out_pixel, exp_valid, exp_addr, exp_pix);
        end
        if (y == 3 && out_valid === 1'b1) n_y3++;
      end
    end
    n_cmp++;
    if (n_y3 != 0 || out_valid !== 1'b1 || out_addr !== 17'd640) begin
      n_err++;
      $display("FAIL resume got y3_strobes=%0d v=%b a=%0d want 0 1 640", n_y3, out_valid, out_addr);
    end
  endtask

  task automatic test_out_of_range();
    int n_oor = 0;
    for (int x = 0; x < 640; x++) step(1'b1, x, 10, 12'($urandom));
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0)      step(1'b1, 700, 500, 12'($urandom));
      else if (i % 3 == 1) step(1'b1, $urandom_range(640, 1023), $urandom_range(0, 479), 12'($urandom));
      else                 step(1'b1, $urandom_range(0, 639), $urandom_range(480, 1023), 12'($urandom));
      if (out_valid === 1'b1) n_oor++;
    end
    n_cmp++;
    if (n_oor != 0) begin
      n_err++;
      $display("FAIL oor_strobes got %0d want 0", n_oor);
    end
    for (int x = 0; x < 640; x++) begin
      step(1'b1, x, 11, 12'($urandom));
      n_cmp++;
      if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL oor_after x=%0d got v=%b a=%0d p=%h want v=%b a=%0d p=%h", x,
                 out_valid, out_addr, out_pixel, exp_valid, exp_addr, exp_pix);
      end
    end
  endtask

  task automatic test_uniform();
    int n_str = 0, n_bad = 0, n_done = 0;
    logic [16:0] done_addr = '0;
    for (int i = 0; i < 8; i++) begin
      for (int x = 0; x < 640; x++) begin
        step(1'b1, x, (i < 4) ? i : 472 + i, 12'hABC);
        n_cmp++;
        if (out_valid !== exp_valid || out_addr !== exp_addr || out_pixel !== exp_pix || frame_done !== exp_done) begin
          n_err++;
          $display("FAIL uniform i=%0d x=%0d got v=%b a=%0d p=%h d=%b want v=%b a=%0d p=%h d=%b", i, x,
                   out_valid, out_addr, out_pixel, frame_done, exp_valid, exp_addr, exp_pix, exp_done);
        end
        if (out_valid === 1'b1) begin
          n_str++;
          if (out_pixel !== 12'hABC) n_bad++;
        end
        if (frame_done === 1'b1) begin
          n_done++;
          done_addr = out_addr;
        end
      end
    end
    step(1'b0, 0, 0, 12'h000);
    n_cmp++;
    if (n_str != 1280 || n_bad != 0 || n_done != 1 || done_addr !== 17'd76799) begin
      n_err++;
      $display("FAIL uniform_totals got strobes=%0d bad=%0d done=%0d done_addr=%0d want 1280 0 1 76799",
               n_str, n_bad, n_done, done_addr);
    end
  endtask

  initial begin
    test_reset();
    test_block();
    test_rounding();
    test_gap();
    test_random();
    test_reset_mid();
    test_out_of_range();
    test_uniform();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
